// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, CHK} cmd_state_t;

  localparam int unsigned FRAME_BYTES  = 5;
  localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;

  function automatic logic [7:0] frame_csum(input logic [7:0] c,
                                            input logic [7:0] hi,
                                            input logic [7:0] lo);
    return c ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Receiver-side byte handshake plus downstream command handshake.
interface uart_cmd_ctrl_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        frame_err;
  logic        timeout;

  modport master (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output clr_rdy, cmd_rdy, cmd, data, frame_err, timeout
  );

  modport slave (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  clr_rdy, cmd_rdy, cmd, data, frame_err, timeout
  );
endinterface

// File: rtl/uart_cmd_tmr.sv
// Inter-byte timeout counter; expired flags the last idle cycle of the window.
module uart_cmd_tmr #(
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned     TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer;

  assign expired = run && !clr && (timer == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (clr || expired) begin
      timer <= '0;
    end else if (run) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 5-byte command frames from the UART receiver and hands
// validated commands to the downstream processor.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_ctrl_if.master bus
);

  cmd_state_t state, state_n;
  logic       accept, expired;
  logic       good, bad, hdr_start;
  logic [7:0] cmd_q, dhi_q, dlo_q;

  // clr_rdy gate stops a byte being consumed twice while rdy is still falling
  assign accept = bus.rx_rdy && !bus.clr_rdy;

  uart_cmd_tmr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept || (state == IDLE)),
    .run     (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    good      = 1'b0;
    bad       = 1'b0;
    hdr_start = 1'b0;
    if (expired) begin
      state_n = IDLE;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (bus.rx_data == HDR_BYTE) begin
            state_n   = CMD;
            hdr_start = 1'b1;
          end
        end
        CMD: state_n = DHI;
        DHI: state_n = DLO;
        DLO: state_n = CHK;
        CHK: begin
          state_n = IDLE;
          if (bus.rx_data == frame_csum(cmd_q, dhi_q, dlo_q)) good = 1'b1;
          else                                                bad  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.clr_rdy   <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.cmd_rdy   <= 1'b0;
      bus.cmd       <= '0;
      bus.data      <= '0;
      cmd_q         <= '0;
      dhi_q         <= '0;
      dlo_q         <= '0;
    end else begin
      bus.clr_rdy   <= accept;
      bus.frame_err <= bad;
      bus.timeout   <= expired;
      if (accept && state == CMD) cmd_q <= bus.rx_data;
      if (accept && state == DHI) dhi_q <= bus.rx_data;
      if (accept && state == DLO) dlo_q <= bus.rx_data;
      if (good) begin
        bus.cmd  <= cmd_q;
        bus.data <= {dhi_q, dlo_q};
      end
      // set has priority so a completed frame is never lost to a clear
      if (good)                                bus.cmd_rdy <= 1'b1;
      else if (bus.clr_cmd_rdy || hdr_start)   bus.cmd_rdy <= 1'b0;
    end
  end

endmodule
